mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between the instruction-fetch requester (IF) and the
//  load/store requester (LS) of the RISC-V core. Arbitrates per cycle, forwards the winner to
//  memory, and routes in-order read responses back to their owner via an owner FIFO.
//  Sits between the fetch/execute units and the memory model.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  MAX_OUT     2   max outstanding reads (owner FIFO depth, >=1)
//  STARVE_LIM  4   consecutive lost cycles after which IF is forced to win once
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous active-low reset
//  if_req     in   1       IF read request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  IF read address
//  if_gnt     out  1       IF request accepted this cycle
//  if_rvalid  out  1       IF read data valid
//  if_rdata   out  DATA_W  IF read data
//  ls_req     in   1       LS request; held with ls_we/addr/wdata until ls_gnt
//  ls_we      in   1       1 = write, 0 = read
//  ls_addr    in   ADDR_W  LS address
//  ls_wdata   in   DATA_W  LS write data
//  ls_gnt     out  1       LS request accepted this cycle
//  ls_rvalid  out  1       LS read data valid
//  ls_rdata   out  DATA_W  LS read data
//  mem_req    out  1       memory request valid
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_ready  in   1       memory accepts request this cycle
//  mem_rvalid in   1       memory read data valid (in order, reads only)
//  mem_rdata  in   DATA_W  memory read data
//  err        out  1       sticky: mem_rvalid received with owner FIFO empty
// BEHAVIOUR
//  - Reset: FIFO count/pointers 0, starve counter 0, err 0; all grants/rvalids/mem_req 0.
//  - Eligibility: a read is eligible only if FIFO count < MAX_OUT; writes are always eligible.
//    Full FIFO blocks reads even if mem_rvalid pops in the same cycle (no rvalid->gnt path).
//  - Winner: LS if ls_req eligible, else IF if if_req eligible; exception: when starve_cnt ==
//    STARVE_LIM and IF eligible, IF wins.
//  - mem_req = winner exists; mem_* driven combinationally from winner; *_gnt = winner & mem_ready.
//  - starve_cnt: +1 each cycle if_req=1 and if_gnt=0 (saturates at STARVE_LIM); 0 on if_gnt or !if_req.
//  - Read grant pushes owner bit (0=IF,1=LS) into FIFO; write grant pushes nothing.
//  - mem_rvalid pops FIFO head; raises if_rvalid or ls_rvalid same cycle (combinational),
//    rdata = mem_rdata to both. Push+pop same cycle: count unchanged.
//  - mem_rvalid with FIFO empty: dropped, no rvalid, err set until reset.
//  - Reset mid-operation: FIFO flushed; late responses from pre-reset reads set err.
//  - Pointers wrap modulo MAX_OUT.
// CONFIGURATION
//  ARB_PERF_EN defined: adds outputs if_stall_cnt, ls_stall_cnt (16 bit), +1 each cycle
//  the requester has req=1 and gnt=0, saturate at 16'hFFFF, reset 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. IF read only, mem_ready=1, addr 0x10 -> if_gnt same cycle, mem_addr=0x10; rvalid
//     2 cycles later with 0xDEAD -> if_rvalid=1, if_rdata=0xDEAD, ls_rvalid=0.
//  2. IF and LS read together, ready=1 -> ls_gnt first; IF granted next cycle; responses
//     A,B -> ls_rvalid on A, if_rvalid on B.
//  3. LS writes back-to-back, IF requesting -> IF loses 4 cycles, 5th cycle if_gnt=1,
//     ls_gnt=0; starve_cnt returns to 0.
//  4. Two reads granted, no rvalid (MAX_OUT=2) -> further reads get no gnt, LS write still
//     granted; one rvalid -> read granted next cycle.
//  5. mem_rvalid with empty FIFO -> no rvalid out, err=1 held; rst_n low -> err=0.
//  6. Assert rst_n mid-transfer with 1 outstanding -> count 0, gnts 0 during reset; ARB_PERF_EN:
//     LS held 3 stalled cycles -> ls_stall_cnt=3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LS shared memory port arbiter with in-order owner FIFO; optional stall counters under ARB_PERF_EN
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
`ifdef ARB_PERF_EN
  ,
  output logic [15:0]       if_stall_cnt,
  output logic [15:0]       ls_stall_cnt
`endif
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int STV_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  logic [MAX_OUT-1:0] owner_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [STV_W-1:0]   starve_cnt;

  logic rd_ok;
  logic if_elig;
  logic ls_elig;
  logic starved;
  logic pick_if;
  logic pick_ls;
  logic push;
  logic pop;
  logic head_ls;

  // Arbitration, memory-side drive and response routing; outputs are held quiet while in reset
  always_comb begin
    rd_ok     = (count < CNT_W'(MAX_OUT));
    ls_elig   = rst_n & ls_req & (ls_we | rd_ok);
    if_elig   = rst_n & if_req & rd_ok;
    starved   = (starve_cnt == STV_W'(STARVE_LIM));
    pick_if   = if_elig & (starved | ~ls_elig);
    pick_ls   = ls_elig & ~pick_if;
    mem_req   = pick_if | pick_ls;
    mem_we    = pick_ls & ls_we;
    mem_addr  = pick_ls ? ls_addr : if_addr;
    mem_wdata = ls_wdata;
    if_gnt    = pick_if & mem_ready;
    ls_gnt    = pick_ls & mem_ready;
    push      = if_gnt | (ls_gnt & ~ls_we);
    pop       = rst_n & mem_rvalid & (count != '0);
    head_ls   = owner_q[rd_ptr];
    if_rvalid = pop & ~head_ls;
    ls_rvalid = pop & head_ls;
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
  end

  // Owner FIFO: one bit per outstanding read, 0 = IF, 1 = LS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= ls_gnt;
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Count consecutive IF losses so a busy LS cannot lock fetch out indefinitely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (!starved) starve_cnt <= starve_cnt + STV_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (mem_rvalid && count == '0) begin
      err <= 1'b1;
    end
  end

`ifdef ARB_PERF_EN
  // Saturating per-requester stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stall_cnt <= '0;
      ls_stall_cnt <= '0;
    end else begin
      if (if_req && !if_gnt && if_stall_cnt != 16'hFFFF) if_stall_cnt <= if_stall_cnt + 16'd1;
      if (ls_req && !ls_gnt && ls_stall_cnt != 16'hFFFF) ls_stall_cnt <= ls_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req, ls_req, ls_we, mem_ready, mem_rvalid;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, err;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
`ifdef ARB_PERF_EN
  logic [15:0]   if_stall_cnt, ls_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO), .STARVE_LIM(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err(err)
`ifdef ARB_PERF_EN
    , .if_stall_cnt(if_stall_cnt), .ls_stall_cnt(ls_stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of owners of outstanding reads, loss streak, sticky error
  typedef struct {
    logic          if_gnt, ls_gnt, mem_req, mem_we, if_rv, ls_rv;
    logic [AW-1:0] addr;
  } exp_t;

  bit oq[$];
  int starve_m = 0;
  bit err_m = 0;
  int ifs_m = 0;
  int lss_m = 0;
  bit last_if_gnt = 0;
  bit last_ls_gnt = 0;

  function automatic exp_t predict();
    exp_t e;
    bit rd_ok, ifw, lsw;
    e = '{default: '0};
    if (!rst_n) return e;
    rd_ok = oq.size() < MO;
    lsw = ls_req && (ls_we || rd_ok);
    ifw = if_req && rd_ok;
    if (ifw && (starve_m == SL || !lsw)) begin
      e.mem_req = 1; e.addr = if_addr; e.if_gnt = mem_ready;
    end else if (lsw) begin
      e.mem_req = 1; e.mem_we = ls_we; e.addr = ls_addr; e.ls_gnt = mem_ready;
    end
    if (mem_rvalid && oq.size() > 0) begin
      if (oq[0]) e.ls_rv = 1; else e.if_rv = 1;
    end
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        oq.delete(); starve_m = 0; err_m = 0; ifs_m = 0; lss_m = 0;
        last_if_gnt = 0; last_ls_gnt = 0;
      end else begin
        e = predict();
        last_if_gnt = e.if_gnt;
        last_ls_gnt = e.ls_gnt;
        if (mem_rvalid && oq.size() == 0) err_m = 1;
        if (e.if_rv || e.ls_rv) void'(oq.pop_front());
        if (e.if_gnt) oq.push_back(1'b0);
        if (e.ls_gnt && !ls_we) oq.push_back(1'b1);
        if (if_req && !e.if_gnt) starve_m = (starve_m < SL) ? starve_m + 1 : SL;
        else starve_m = 0;
        if (if_req && !e.if_gnt && ifs_m < 65535) ifs_m++;
        if (ls_req && !e.ls_gnt && lss_m < 65535) lss_m++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      e = predict();
      chk("if_gnt", if_gnt, e.if_gnt);
      chk("ls_gnt", ls_gnt, e.ls_gnt);
      chk("mem_req", mem_req, e.mem_req);
      chk("if_rvalid", if_rvalid, e.if_rv);
      chk("ls_rvalid", ls_rvalid, e.ls_rv);
      chk("err", err, err_m);
      if (e.mem_req) begin
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", mem_we, e.mem_we);
        if (e.mem_we) chk("mem_wdata", mem_wdata, ls_wdata);
      end
      if (e.if_rv) chk("if_rdata", if_rdata, mem_rdata);
      if (e.ls_rv) chk("ls_rdata", ls_rdata, mem_rdata);
`ifdef ARB_PERF_EN
      chk("if_stall_cnt", if_stall_cnt, ifs_m);
      chk("ls_stall_cnt", ls_stall_cnt, lss_m);
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  initial begin
    if_req = 0; ls_req = 0; ls_we = 0; mem_ready = 0; mem_rvalid = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    tick();
    if_req = 1; ls_req = 1; mem_ready = 1;
    probe();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_err", err, 0);
    tick();
    if_req = 0; ls_req = 0; rst_n = 1;

    // Single IF read, response two cycles later
    if_req = 1; if_addr = 32'h10;
    probe(); chk("t1_if_gnt", if_gnt, 1); chk("t1_mem_addr", mem_addr, 32'h10); tick();
    if_req = 0;
    probe(); tick();
    mem_rvalid = 1; mem_rdata = 32'hDEAD;
    probe(); chk("t1_if_rvalid", if_rvalid, 1); chk("t1_if_rdata", if_rdata, 32'hDEAD);
    chk("t1_ls_rvalid", ls_rvalid, 0); tick();
    mem_rvalid = 0;

    // Starvation: LS writes back to back, IF loses four cycles then wins once
    ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'h1234; if_req = 1; if_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      probe(); chk("t3_ls_win", ls_gnt, 1); chk("t3_if_lose", if_gnt, 0); tick();
    end
    probe(); chk("t3_if_forced", if_gnt, 1); chk("t3_ls_held", ls_gnt, 0); tick();
    probe(); chk("t3_starve_clear", if_gnt, 0); chk("t3_ls_again", ls_gnt, 1); tick();
    if_req = 0; ls_req = 0; mem_rvalid = 1; mem_rdata = 32'h5;
    probe(); chk("t3_if_rvalid", if_rvalid, 1); tick();
    mem_rvalid = 0;

    // Simultaneous reads, FIFO full blocking, writes still pass
    ls_req = 1; ls_we = 0; ls_addr = 32'h200; if_req = 1; if_addr = 32'h30;
    probe(); chk("t2_ls_first", ls_gnt, 1); chk("t2_if_wait", if_gnt, 0); tick();
    ls_req = 0;
    probe(); chk("t2_if_next", if_gnt, 1); tick();
    ls_req = 1; ls_we = 0;
    probe(); chk("t4_full_if", if_gnt, 0); chk("t4_full_ls", ls_gnt, 0); chk("t4_full_req", mem_req, 0); tick();
    ls_we = 1;
    probe(); chk("t4_write_pass", ls_gnt, 1); tick();
    ls_req = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA;
    probe(); chk("t2_ls_rvalid", ls_rvalid, 1); chk("t2_ls_rdata", ls_rdata, 32'hAAAA);
    chk("t4_pop_no_gnt", if_gnt, 0); tick();
    mem_rvalid = 0;
    probe(); chk("t4_after_pop", if_gnt, 1); tick();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'hBBBB;
    probe(); chk("t2_if_rvalid", if_rvalid, 1); chk("t2_if_rdata", if_rdata, 32'hBBBB); tick();
    probe(); chk("t4_drain", if_rvalid, 1); tick();
    mem_rvalid = 0;

    // Spurious response with empty FIFO
    mem_rvalid = 1;
    probe(); chk("t5_no_if_rv", if_rvalid, 0); chk("t5_no_ls_rv", ls_rvalid, 0); tick();
    mem_rvalid = 0;
    probe(); chk("t5_err", err, 1); tick();
    probe(); chk("t5_err_held", err, 1);
    rst_n = 0;
    probe(); chk("t5_err_cleared", err, 0); tick();
    rst_n = 1;

    // Reset with a read outstanding, then a late response
    if_req = 1; if_addr = 32'h40;
    probe(); chk("t6_gnt", if_gnt, 1); tick();
    ls_req = 1; ls_we = 0; rst_n = 0;
    probe(); chk("t6_rst_if_gnt", if_gnt, 0); chk("t6_rst_ls_gnt", ls_gnt, 0);
    chk("t6_rst_mem_req", mem_req, 0); tick();
    rst_n = 1; if_req = 0; ls_req = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    probe(); chk("t6_late_no_rv", if_rvalid, 0); tick();
    mem_rvalid = 0;
    probe(); chk("t6_late_err", err, 1); tick();
`ifdef ARB_PERF_EN
    rst_n = 0; tick(); rst_n = 1;
    ls_req = 1; ls_we = 1; mem_ready = 0;
    tick(); tick(); tick();
    probe(); chk("t6_ls_stall", ls_stall_cnt, 16'd3); tick();
    ls_req = 0; mem_ready = 1; tick();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if (!if_req || last_if_gnt) begin
        if_req = ($urandom % 3) != 0; if_addr = $urandom;
      end
      if (!ls_req || last_ls_gnt) begin
        ls_req = ($urandom % 3) != 0; ls_we = $urandom % 2; ls_addr = $urandom; ls_wdata = $urandom;
      end
      mem_ready = ($urandom % 4) != 0;
      mem_rvalid = (oq.size() > 0 && ($urandom % 2) == 1) || ($urandom % 64 == 0);
      mem_rdata = $urandom;
      rst_n = ($urandom % 800) != 0;
      tick();
    end
    rst_n = 1; if_req = 0; ls_req = 0; mem_rvalid = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
